// File: rtl/ir_tx_pkg.sv
// rtl/ir_tx_pkg.sv - shared timing table, state encoding and helpers for the IR packet transmitter
package ir_tx_pkg;

    typedef struct packed {
        logic [31:0] carrier_hz;
        logic [7:0]  start_len;
        logic [7:0]  gap_len;
        logic [7:0]  select_len;
        logic [7:0]  assert_len;
        logic [7:0]  deassert_len;
    } car_timing_t;

    // Upper four entries mirror the lower four so a 3-bit car index never leaves the table.
    localparam car_timing_t CAR_TIMING [0:7] = '{
        '{32'd36000, 8'd191, 8'd25, 8'd47, 8'd47, 8'd22},
        '{32'd40000, 8'd88,  8'd40, 8'd22, 8'd44, 8'd22},
        '{32'd37500, 8'd88,  8'd40, 8'd44, 8'd44, 8'd22},
        '{32'd36000, 8'd192, 8'd24, 8'd24, 8'd48, 8'd24},
        '{32'd36000, 8'd191, 8'd25, 8'd47, 8'd47, 8'd22},
        '{32'd40000, 8'd88,  8'd40, 8'd22, 8'd44, 8'd22},
        '{32'd37500, 8'd88,  8'd40, 8'd44, 8'd44, 8'd22},
        '{32'd36000, 8'd192, 8'd24, 8'd24, 8'd48, 8'd24}
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        GAP    = 3'd2,
        SELECT = 3'd3,
        BIT    = 3'd4,
        DONE   = 3'd5
    } tx_state_t;

    // Largest carrier half-period in the table, used to size the carrier counter.
    function automatic int max_half_period(input int sys_hz);
        int m;
        m = 1;
        for (int i = 0; i < 8; i++) begin
            if (sys_hz / (2 * int'(CAR_TIMING[i].carrier_hz)) > m) begin
                m = sys_hz / (2 * int'(CAR_TIMING[i].carrier_hz));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ir_packet_tx_if.sv
// rtl/ir_packet_tx_if.sv - controller-side bundle of the IR packet transmitter
interface ir_packet_tx_if #(
    parameter int CMD_LEN   = 4,
    parameter int CAR_COUNT = 4
);
    localparam int SEL_W = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1;

    logic               enable;
    logic               send_now;
    logic [CMD_LEN-1:0] command;
    logic [SEL_W-1:0]   car_sel;
    logic [SEL_W-1:0]   leds;
    logic               busy;
    logic               packet_done;
    logic               ir_led;

    modport master (
        output enable, send_now, command, car_sel,
        input  leds, busy, packet_done, ir_led
    );

    modport slave (
        input  enable, send_now, command, car_sel,
        output leds, busy, packet_done, ir_led
    );
endinterface

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - square-wave carrier with runtime half-period and phase reset
module ir_carrier_gen #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] half_period,
    input  logic         phase_reset,
    output logic         level,
    output logic         period_end
);
    logic [W-1:0] cnt;
    logic         half_end;

    // >= keeps the counter bounded if the half-period shrinks while counting.
    assign half_end   = (cnt >= half_period - W'(1));
    assign period_end = half_end && !level;

    // Count out each half; phase reset restarts at the beginning of a high half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (phase_reset) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (half_end) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/ir_packet_tx.sv
// rtl/ir_packet_tx.sv - periodic / on-demand IR packet transmitter top
module ir_packet_tx
    import ir_tx_pkg::*;
#(
    parameter int SYS_CLK_FREQ_HZ           = 100000000,
    parameter int TRANSMISSION_FREQUENCY_HZ = 10,
    parameter int CAR_COUNT                 = 4,
    parameter int CMD_LEN                   = 4,
    parameter int SEND_ON_CHANGE            = 1
) (
    input logic           clk,
    input logic           rst,
    ir_packet_tx_if.slave bus
);
    localparam int PERIOD = SYS_CLK_FREQ_HZ / TRANSMISSION_FREQUENCY_HZ;
    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CW     = $clog2(max_half_period(SYS_CLK_FREQ_HZ) + 1);
    localparam int SEL_W  = (CAR_COUNT > 1) ? $clog2(CAR_COUNT) : 1;

    tx_state_t          state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [7:0]         burst_cnt;
    logic [2:0]         bit_idx;
    logic               select_done;
    logic               pending;
    logic [CMD_LEN-1:0] last_cmd;
    logic [2:0]         car_idx;
    logic [SEL_W-1:0]   leds_q;

    logic               tick;
    logic               req;
    logic               change;
    logic [2:0]         new_car;
    logic [7:0]         cmd_pad;
    logic [7:0]         seg_len;
    logic               seg_end;
    logic [CW-1:0]      half_tab [0:7];
    logic               carrier_level;
    logic               period_end;
    logic               burst_phase;

    assign tick    = (tick_cnt == TICK_W'(PERIOD - 1)) && bus.enable;
    assign req     = tick || bus.send_now;
    assign change  = (SEND_ON_CHANGE != 0) && (bus.command != last_cmd);
    assign new_car = (int'(bus.car_sel) < CAR_COUNT) ? 3'(bus.car_sel) : 3'd0;
    assign cmd_pad = 8'(last_cmd);

    // Half-periods are fixed per table entry, so they fold into constants.
    for (genvar g = 0; g < 8; g++) begin : g_half
        assign half_tab[g] = CW'(SYS_CLK_FREQ_HZ / (2 * int'(CAR_TIMING[g].carrier_hz)));
    end

    ir_carrier_gen #(.W(CW)) u_carrier (
        .clk         (clk),
        .rst         (rst),
        .half_period (half_tab[car_idx]),
        .phase_reset ((state == IDLE) || (state == DONE)),
        .level       (carrier_level),
        .period_end  (period_end)
    );

    // Period tick counter free-runs regardless of ENABLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_W'(PERIOD - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Length of the current segment in carrier periods for the latched car.
    always_comb begin
        seg_len = 8'd0;
        case (state)
            START:   seg_len = CAR_TIMING[car_idx].start_len;
            GAP:     seg_len = CAR_TIMING[car_idx].gap_len;
            SELECT:  seg_len = CAR_TIMING[car_idx].select_len;
            BIT:     seg_len = cmd_pad[bit_idx] ? CAR_TIMING[car_idx].assert_len
                                                : CAR_TIMING[car_idx].deassert_len;
            default: seg_len = 8'd0;
        endcase
    end

    assign seg_end = period_end && (burst_cnt == seg_len - 8'd1);

    // Packet sequencer: start/select/bit bursts separated by gaps, then DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            burst_cnt   <= 8'd0;
            bit_idx     <= 3'd0;
            select_done <= 1'b0;
            pending     <= 1'b0;
            last_cmd    <= '0;
            car_idx     <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (req || (state == IDLE && change) || (state == DONE && pending)) begin
                        state       <= START;
                        car_idx     <= new_car;
                        last_cmd    <= bus.command;
                        burst_cnt   <= 8'd0;
                        bit_idx     <= 3'd0;
                        select_done <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                    pending <= 1'b0;
                end
                default: begin
                    if (req) begin
                        pending <= 1'b1;
                    end
                    if (period_end) begin
                        if (seg_end) begin
                            burst_cnt <= 8'd0;
                            case (state)
                                START:  state <= GAP;
                                GAP:    state <= select_done ? BIT : SELECT;
                                SELECT: begin
                                    state       <= GAP;
                                    select_done <= 1'b1;
                                end
                                BIT: begin
                                    if (bit_idx == 3'(CMD_LEN - 1)) begin
                                        state <= DONE;
                                    end else begin
                                        bit_idx <= bit_idx + 3'd1;
                                        state   <= GAP;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Car switches mirrored to the LEDs one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= bus.car_sel;
        end
    end

    assign burst_phase     = (state == START) || (state == SELECT) || (state == BIT);
    assign bus.ir_led      = burst_phase && carrier_level;
    assign bus.busy        = (state != IDLE);
    assign bus.packet_done = (state == DONE);
    assign bus.leds        = leds_q;
endmodule

// File: tb/tb_ir_packet_tx.sv
// tb/tb_ir_packet_tx.sv - directed self-checking bench for ir_packet_tx
module tb_ir_packet_tx;
    localparam int SYS = 288000;
    localparam int TXF = 20;
    localparam int PER = SYS / TXF;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   first_hi;
    int   viol;
    int   s;
    int   seq [$];

    ir_packet_tx_if #(.CMD_LEN(4), .CAR_COUNT(3)) bus ();

    ir_packet_tx #(
        .SYS_CLK_FREQ_HZ           (SYS),
        .TRANSMISSION_FREQUENCY_HZ (TXF),
        .CAR_COUNT                 (3),
        .CMD_LEN                   (4),
        .SEND_ON_CHANGE            (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int exp [$]);
        chk({tag, "_len"}, seq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s_seg%0d", tag, i), (i < seq.size()) ? seq[i] : -1, exp[i]);
        end
    endtask

    task automatic wait_busy(input string tag, input int bound);
        int n;
        n = 0;
        while (!bus.busy && n < bound) begin
            step();
            n++;
        end
        chk(tag, bus.busy, 1);
    endtask

    // Called on the first START cycle; records burst/gap lengths in carrier periods
    // until PACKET_DONE, optionally pulsing SEND_NOW at offsets 200, 700, 1200.
    task automatic capture(input int h, input int npulse);
        int  pulses, low, n, hi_run;
        bit  prev, done;
        pulses = 0; low = 0; n = 0; hi_run = 0; prev = 0; done = 0;
        seq.delete();
        first_hi = -1;
        while (!done && n < 20000) begin
            if (bus.ir_led && !prev) begin
                if (pulses > 0 && low > h) begin
                    seq.push_back(pulses);
                    seq.push_back(((low - h) % (2 * h) == 0) ? (low - h) / (2 * h) : -1);
                    pulses = 0;
                end
                pulses++;
                low = 0;
            end
            if (!bus.ir_led) low++;
            if (first_hi < 0) begin
                if (bus.ir_led) hi_run++;
                else first_hi = hi_run;
            end
            prev = bus.ir_led;
            if (bus.packet_done) begin
                seq.push_back(pulses);
                done = 1;
            end else begin
                bus.send_now = (n < 500 * npulse) && (n % 500 == 200);
                step();
                n++;
            end
        end
        bus.send_now = 1'b0;
        chk("capture_done", done, 1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        bus.enable = 1'b0; bus.send_now = 1'b0; bus.command = 4'b0000; bus.car_sel = 2'd2;
        repeat (3) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_led", bus.ir_led, 0);
        chk("rst_done", bus.packet_done, 0);
        chk("rst_leds", bus.leds, 0);

        // Idle with nothing requested
        rst = 1'b0;
        bus.car_sel = 2'd0;
        viol = 0;
        repeat (2000) begin
            step();
            if (bus.ir_led || bus.busy || bus.leds != 0) viol++;
        end
        chk("idle_quiet", viol, 0);

        // Car 0, command 0101 on demand
        bus.command = 4'b0101; bus.send_now = 1'b1;
        step();
        bus.send_now = 1'b0;
        chk("t2_busy_next", bus.busy, 1);
        chk("t2_led_next", bus.ir_led, 1);
        capture(4, 0);
        chk("t2_half", first_hi, 4);
        chk_seq("t2", '{191, 25, 47, 25, 47, 25, 22, 25, 47, 25, 22});
        step();
        chk("t2_single_done", bus.packet_done, 0);
        chk("t2_busy_after", bus.busy, 0);

        // Car 1 periodic; third tick coincides with SEND_NOW
        bus.car_sel = 2'd1; bus.enable = 1'b1;
        wait_busy("t3_start1", PER + 100);
        s = cyc;
        chk("t3_leds", bus.leds, 1);
        capture(3, 0);
        chk("t3_half", first_hi, 3);
        chk_seq("t3a", '{88, 40, 22, 40, 44, 40, 22, 40, 44, 40, 22});
        while (cyc < s + PER - 1) step();
        chk("t3_idle_before2", bus.busy, 0);
        step();
        chk("t3_start2_on_period", bus.busy, 1);
        capture(3, 0);
        chk("t3_half2", first_hi, 3);
        while (cyc < s + 2 * PER - 1) step();
        chk("t3_idle_before3", bus.busy, 0);
        bus.send_now = 1'b1;
        step();
        bus.send_now = 1'b0;
        chk("t3_start3", bus.busy, 1);
        capture(3, 0);
        bus.enable = 1'b0;
        chk_seq("t3c", '{88, 40, 22, 40, 44, 40, 22, 40, 44, 40, 22});
        step();
        chk("t3_tick_send_one_packet", bus.busy, 0);

        // Car 2 with three SEND_NOW pulses collapsing into one pending packet
        bus.car_sel = 2'd2; bus.send_now = 1'b1;
        step();
        bus.send_now = 1'b0;
        chk("t4_busy", bus.busy, 1);
        capture(3, 3);
        chk_seq("t4a", '{88, 40, 44, 40, 44, 40, 22, 40, 44, 40, 22});
        step();
        chk("t4_pend_busy", bus.busy, 1);
        chk("t4_pend_led", bus.ir_led, 1);
        capture(3, 0);
        chk_seq("t4b", '{88, 40, 44, 40, 44, 40, 22, 40, 44, 40, 22});
        viol = 0;
        repeat (300) begin
            step();
            if (bus.busy) viol++;
        end
        chk("t4_no_third", viol, 0);

        // Reset during the first BIT burst of a car-0 packet
        bus.car_sel = 2'd0; bus.send_now = 1'b1;
        step();
        bus.send_now = 1'b0;
        chk("t5_busy", bus.busy, 1);
        repeat (10) step();
        bus.command = 4'b0000;
        repeat (2390) step();
        chk("t5_led_pre", bus.ir_led, 1);
        rst = 1'b1;
        #1;
        chk("t5_led_rst", bus.ir_led, 0);
        chk("t5_busy_rst", bus.busy, 0);
        viol = 0;
        repeat (5) begin
            step();
            if (bus.packet_done) viol++;
        end
        rst = 1'b0;
        bus.car_sel = 2'd3;
        repeat (10) begin
            step();
            if (bus.packet_done || bus.busy) viol++;
        end
        chk("t5_no_done", viol, 0);
        chk("t5_leds_raw", bus.leds, 3);
        bus.send_now = 1'b1;
        step();
        bus.send_now = 1'b0;
        chk("t5_busy_after", bus.busy, 1);
        capture(4, 0);
        chk("t5_half_car0", first_hi, 4);
        chk_seq("t5", '{191, 25, 47, 25, 22, 25, 22, 25, 22, 25, 22});
        step();
        chk("t5_idle_after", bus.busy, 0);

        // Send-on-change: 0000 -> 1000 on car 1
        bus.car_sel = 2'd1; bus.command = 4'b1000;
        step();
        chk("t6_busy", bus.busy, 1);
        capture(3, 0);
        chk_seq("t6", '{88, 40, 22, 40, 22, 40, 22, 40, 22, 40, 44});
        viol = 0;
        repeat (1000) begin
            step();
            if (bus.busy) viol++;
        end
        chk("t6_held_no_repeat", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
